obstacle_manager: RTL and testbench

//  Parametrised successor to the fixed two-slot obstacle generator. Manages NUM_OBS

---
 rtl/obstacle_manager.sv | 121 ++++++++++++
 tb/tb_obstacle_manager.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/obstacle_manager.sv
// Obstacle slot manager: spawns obstacles at SPAWN_X after a randomised gap, scrolls
// them left at a speed that ramps with play time, and retires them at the left edge.
module obstacle_manager #(
  parameter int NUM_OBS        = 2,
  parameter int POS_W          = 9,
  parameter int TYPE_W         = 3,
  parameter int SPAWN_X        = 250,
  parameter int MIN_GAP        = 60,
  parameter int START_SPEED    = 1,
  parameter int MAX_SPEED      = 4,
  parameter int SPEED_UP_TICKS = 600
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      game_tick,
  input  logic                      run,
  input  logic                      clear,
  input  logic [7:0]                rng,
  output logic [NUM_OBS*POS_W-1:0]  obs_pos,
  output logic [NUM_OBS*TYPE_W-1:0] obs_type,
  output logic [NUM_OBS-1:0]        obs_active,
  output logic [3:0]                speed,
  output logic                      spawn_pulse
);

  localparam int TC_W = (SPEED_UP_TICKS > 1) ? $clog2(SPEED_UP_TICKS) : 1;
  localparam logic [POS_W-1:0] GAP_MAX = '1;

  logic [POS_W-1:0] gap_cnt, next_gap;
  logic [TC_W-1:0]  tick_cnt;

  logic [NUM_OBS*POS_W-1:0]  pos_d;
  logic [NUM_OBS*TYPE_W-1:0] typ_d;
  logic [NUM_OBS-1:0]        act_d;
  logic [3:0]                speed_d;
  logic [POS_W-1:0]          gap_d, next_gap_d;
  logic [TC_W-1:0]           tick_d;
  logic                      spawn_d, do_spawn, placed;

  function automatic logic [POS_W-1:0] sat_gap(input logic [POS_W-1:0] gap,
                                               input logic [3:0] spd);
    logic [POS_W:0] sum;
    sum = {1'b0, gap} + (POS_W+1)'(spd);
    return sum[POS_W] ? GAP_MAX : sum[POS_W-1:0];
  endfunction

  function automatic logic [3:0] sat_speed(input logic [3:0] spd);
    return (spd >= 4'(MAX_SPEED)) ? 4'(MAX_SPEED) : spd + 4'd1;
  endfunction

  function automatic logic retires(input logic [POS_W-1:0] pos, input logic [3:0] spd);
    return (POS_W+4)'(pos) < (POS_W+4)'(spd);
  endfunction

  always_comb begin
    pos_d      = obs_pos;
    typ_d      = obs_type;
    act_d      = obs_active;
    speed_d    = speed;
    gap_d      = gap_cnt;
    next_gap_d = next_gap;
    tick_d     = tick_cnt;
    spawn_d    = 1'b0;
    placed     = 1'b0;
    // Spawn decision uses pre-tick occupancy, so a slot retiring now stays empty this tick
    do_spawn   = (gap_cnt >= next_gap) && !(&obs_active);
    if (game_tick && run) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (obs_active[i]) begin
          if (retires(obs_pos[i*POS_W +: POS_W], speed)) begin
            act_d[i]                = 1'b0;
            pos_d[i*POS_W +: POS_W] = '0;
          end else begin
            pos_d[i*POS_W +: POS_W] = obs_pos[i*POS_W +: POS_W] - POS_W'(speed);
          end
        end else if (do_spawn && !placed) begin
          act_d[i]                  = 1'b1;
          pos_d[i*POS_W +: POS_W]   = POS_W'(SPAWN_X);
          typ_d[i*TYPE_W +: TYPE_W] = rng[TYPE_W-1:0];
          placed                    = 1'b1;
        end
      end
      spawn_d = do_spawn;
      if (do_spawn) begin
        gap_d      = '0;
        next_gap_d = POS_W'(MIN_GAP) + POS_W'({rng[7:4], 2'b00});
      end else begin
        gap_d = sat_gap(gap_cnt, speed);
      end
      if (tick_cnt == TC_W'(SPEED_UP_TICKS - 1)) begin
        tick_d  = '0;
        speed_d = sat_speed(speed);
      end else begin
        tick_d = tick_cnt + TC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      obs_pos     <= '0;
      obs_type    <= '0;
      obs_active  <= '0;
      speed       <= 4'(START_SPEED);
      gap_cnt     <= '0;
      next_gap    <= POS_W'(MIN_GAP);
      tick_cnt    <= '0;
      spawn_pulse <= 1'b0;
    end else begin
      obs_pos     <= pos_d;
      obs_type    <= typ_d;
      obs_active  <= act_d;
      speed       <= speed_d;
      gap_cnt     <= gap_d;
      next_gap    <= next_gap_d;
      tick_cnt    <= tick_d;
      spawn_pulse <= spawn_d;
    end
  end

endmodule

// File: tb/tb_obstacle_manager.sv
// Scoreboard bench for obstacle_manager against a behavioural slot model.
module tb_obstacle_manager;
  localparam int NUM_OBS = 2, POS_W = 9, TYPE_W = 3, SPAWN_X = 250, MIN_GAP = 60;
  localparam int START_SPEED = 1, MAX_SPEED = 4, SPEED_UP_TICKS = 600;
  localparam int GAP_SAT = (1 << POS_W) - 1;

  logic clk = 1'b0, rst_n = 1'b0, game_tick = 1'b0, run = 1'b0, clear = 1'b0;
  logic [7:0] rng = 8'h00;
  logic [NUM_OBS*POS_W-1:0]  obs_pos;
  logic [NUM_OBS*TYPE_W-1:0] obs_type;
  logic [NUM_OBS-1:0]        obs_active;
  logic [3:0]                speed;
  logic                      spawn_pulse;

  obstacle_manager #(
    .NUM_OBS(NUM_OBS), .POS_W(POS_W), .TYPE_W(TYPE_W), .SPAWN_X(SPAWN_X),
    .MIN_GAP(MIN_GAP), .START_SPEED(START_SPEED), .MAX_SPEED(MAX_SPEED),
    .SPEED_UP_TICKS(SPEED_UP_TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .game_tick(game_tick), .run(run), .clear(clear),
    .rng(rng), .obs_pos(obs_pos), .obs_type(obs_type), .obs_active(obs_active),
    .speed(speed), .spawn_pulse(spawn_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_OBS*POS_W-1:0]  pos;
    logic [NUM_OBS*TYPE_W-1:0] typ;
    logic [NUM_OBS-1:0]        act;
    logic [3:0]                spd;
    logic                      pulse;
  } exp_t;
  exp_t exp_q[$];

  int n_pass = 0, n_total = 0;

  // Behavioural model state
  int m_pos[NUM_OBS], m_typ[NUM_OBS];
  bit m_act[NUM_OBS];
  int m_gap, m_next_gap, m_run_ticks;
  bit m_pulse;

  function automatic int m_speed();
    int s = START_SPEED + m_run_ticks / SPEED_UP_TICKS;
    return (s > MAX_SPEED) ? MAX_SPEED : s;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NUM_OBS; i++) begin m_pos[i] = 0; m_typ[i] = 0; m_act[i] = 0; end
    m_gap = 0; m_next_gap = MIN_GAP; m_run_ticks = 0; m_pulse = 0;
  endtask

  task automatic m_tick(input int r);
    int spd = m_speed();
    int free = -1;
    for (int i = NUM_OBS - 1; i >= 0; i--) if (!m_act[i]) free = i;
    m_pulse = (m_gap >= m_next_gap) && (free >= 0);
    for (int i = 0; i < NUM_OBS; i++)
      if (m_act[i]) begin
        if (m_pos[i] < spd) begin m_act[i] = 0; m_pos[i] = 0; end
        else m_pos[i] = m_pos[i] - spd;
      end
    if (m_pulse) begin
      m_pos[free] = SPAWN_X; m_typ[free] = r % (1 << TYPE_W); m_act[free] = 1;
      m_gap = 0; m_next_gap = MIN_GAP + (r / 16) * 4;
    end else begin
      m_gap = (m_gap + spd > GAP_SAT) ? GAP_SAT : m_gap + spd;
    end
    m_run_ticks++;
  endtask

  function automatic exp_t m_snapshot();
    exp_t e;
    for (int i = 0; i < NUM_OBS; i++) begin
      e.pos[i*POS_W +: POS_W]   = POS_W'(m_pos[i]);
      e.typ[i*TYPE_W +: TYPE_W] = TYPE_W'(m_typ[i]);
      e.act[i]                  = m_act[i];
    end
    e.spd = 4'(m_speed());
    e.pulse = m_pulse;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    else n_pass++;
  endtask

  // Drive one cycle of inputs and push the expected post-edge outputs
  task automatic step(input bit rn, input bit clr, input bit tk, input bit rr, input int r);
    @(negedge clk);
    rst_n = rn; clear = clr; game_tick = tk; run = rr; rng = 8'(r);
    if (!rn || clr) m_reset();
    else if (tk && rr) m_tick(r);
    else m_pulse = 0;
    exp_q.push_back(m_snapshot());
  endtask

  task automatic after_edge();
    @(posedge clk); #3;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("obs_pos", 64'(obs_pos), 64'(e.pos));
      chk("obs_type", 64'(obs_type), 64'(e.typ));
      chk("obs_active", 64'(obs_active), 64'(e.act));
      chk("speed", 64'(speed), 64'(e.spd));
      chk("spawn_pulse", 64'(spawn_pulse), 64'(e.pulse));
    end
  end

  initial begin
    logic [NUM_OBS*POS_W-1:0] pos_frozen;
    int wait_cnt;
    m_reset();
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 8'hff);
    after_edge();
    chk("reset_active", 64'(obs_active), 64'd0);
    chk("reset_speed", 64'(speed), 64'(START_SPEED));
    step(1, 1, 0, 1, 0);

    // Spawn timing with rng=0: first spawn on tick 61
    for (int t = 1; t <= 60; t++) step(1, 0, 1, 1, 0);
    after_edge();
    chk("no_spawn_before_61", 64'(spawn_pulse), 64'd0);
    step(1, 0, 1, 1, 0);
    after_edge();
    chk("spawn_61_pulse", 64'(spawn_pulse), 64'd1);
    chk("spawn_61_active", 64'(obs_active), 64'b01);
    chk("spawn_61_pos", 64'(obs_pos[POS_W-1:0]), 64'(SPAWN_X));
    chk("spawn_61_type", 64'(obs_type[TYPE_W-1:0]), 64'd0);

    // Movement to the left edge, retirement, then the deferred refill of slot 0
    for (int t = 62; t <= 311; t++) step(1, 0, 1, 1, 0);
    after_edge();
    chk("slot0_at_zero", 64'(obs_pos[POS_W-1:0]), 64'd0);
    chk("slot0_still_live", 64'(obs_active[0]), 64'd1);
    chk("both_full", 64'(obs_active), 64'b11);
    step(1, 0, 1, 1, 0);
    after_edge();
    chk("slot0_retired", 64'(obs_active[0]), 64'd0);
    chk("slot0_no_wrap", 64'(obs_pos[POS_W-1:0]), 64'd0);
    chk("no_refill_same_tick", 64'(spawn_pulse), 64'd0);
    step(1, 0, 1, 1, 0);
    after_edge();
    chk("deferred_spawn_pulse", 64'(spawn_pulse), 64'd1);
    chk("deferred_spawn_slot0", 64'(obs_pos[POS_W-1:0]), 64'(SPAWN_X));

    // Randomised play, long enough to ramp speed to its ceiling and hold it
    while (m_run_ticks < 3000) begin
      int r = int'($urandom_range(0, 255));
      bit tk = ($urandom_range(0, 9) != 0);
      bit rr = ($urandom_range(0, 19) != 0);
      step(1, 0, tk, rr, r);
    end
    after_edge();
    chk("speed_ceiling", 64'(speed), 64'(MAX_SPEED));

    // Freeze: ticks with run=0 change nothing
    pos_frozen = obs_pos;
    for (int t = 0; t < 100; t++) step(1, 0, 1, 0, int'($urandom_range(0, 255)));
    after_edge();
    chk("freeze_pos", 64'(obs_pos), 64'(pos_frozen));
    chk("freeze_pulse", 64'(spawn_pulse), 64'd0);

    // Clear together with a tick mid-game, then reset mid-game
    step(1, 1, 1, 1, 8'h5a);
    after_edge();
    chk("clear_tick_active", 64'(obs_active), 64'd0);
    chk("clear_tick_speed", 64'(speed), 64'd1);
    for (int t = 0; t < 200; t++) step(1, 0, 1, 1, int'($urandom_range(0, 255)));
    step(0, 0, 1, 1, 8'h33);
    after_edge();
    chk("rst_mid_pos", 64'(obs_pos), 64'd0);
    chk("rst_mid_speed", 64'(speed), 64'd1);
    for (int t = 0; t < 20; t++) step(1, 0, 1, 1, int'($urandom_range(0, 255)));

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin @(posedge clk); #3; wait_cnt++; end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
